load_data_unit: RTL

Multi-cycle load path for the RV32I core: accepts a load request (address and func3), issues one or two word-aligned reads to data memory, then aligns and sign- or zero-extends the addressed bytes into a 32-bit result. It sits between the execute stage and the data-memory read port. It is the read-side counterpart of the store byte-enable logic. Misaligned halfword and word loads are split into two word reads.

---
 rtl/load_data_unit.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/load_data_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_data_unit
// Purpose  : RV32I multi-cycle load path; one or two word reads, then align and extend
// Revision : 1.0  initial release
// ============================================================================
module load_data_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_func3,
  output logic        mem_rd_valid,
  input  logic        mem_rd_ready,
  output logic [31:0] mem_rd_addr,
  input  logic        mem_rdata_valid,
  input  logic [31:0] mem_rdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD0   = 3'd1,
    WAIT0 = 3'd2,
    RD1   = 3'd3,
    WAIT1 = 3'd4,
    RESP  = 3'd5
  } state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  state_t      state;
  logic [1:0]  offset;
  logic [2:0]  func3;
  logic        split;
  logic [31:0] word0;

  function automatic logic is_legal(input logic [2:0] f);
    return (f == F3_LB) || (f == F3_LH) || (f == F3_LW) ||
           (f == F3_LBU) || (f == F3_LHU);
  endfunction

  // A load crosses a word boundary when its last byte lives in the next word.
  function automatic logic needs_split(input logic [2:0] f, input logic [1:0] off);
    return ((f == F3_LH || f == F3_LHU) && off == 2'd3) ||
           ((f == F3_LW) && off != 2'd0);
  endfunction

  function automatic logic [31:0] align_extend(input logic [31:0] hi,
                                               input logic [31:0] lo,
                                               input logic [1:0]  off,
                                               input logic [2:0]  f);
    logic [31:0] raw;
    raw = 32'({hi, lo} >> {off, 3'b000});
    case (f)
      F3_LB:   return {{24{raw[7]}}, raw[7:0]};
      F3_LBU:  return {24'h0, raw[7:0]};
      F3_LH:   return {{16{raw[15]}}, raw[15:0]};
      F3_LHU:  return {16'h0, raw[15:0]};
      default: return raw;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      req_ready    <= 1'b1;
      mem_rd_valid <= 1'b0;
      mem_rd_addr  <= 32'h0;
      rsp_valid    <= 1'b0;
      rsp_data     <= 32'h0;
      rsp_err      <= 1'b0;
      offset       <= 2'd0;
      func3        <= 3'd0;
      split        <= 1'b0;
      word0        <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            offset    <= req_addr[1:0];
            func3     <= req_func3;
            split     <= needs_split(req_func3, req_addr[1:0]);
            req_ready <= 1'b0;
            if (!is_legal(req_func3)) begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_data  <= 32'h0;
              state     <= RESP;
            end else begin
              mem_rd_valid <= 1'b1;
              mem_rd_addr  <= {req_addr[31:2], 2'b00};
              state        <= RD0;
            end
          end
        end
        RD0: begin
          if (mem_rd_ready) begin
            mem_rd_valid <= 1'b0;
            state        <= WAIT0;
          end
        end
        WAIT0: begin
          if (mem_rdata_valid) begin
            word0 <= mem_rdata;
            if (split) begin
              mem_rd_valid <= 1'b1;
              mem_rd_addr  <= mem_rd_addr + 32'd4;  // wraps naturally at 2^32
              state        <= RD1;
            end else begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b0;
              rsp_data  <= align_extend(32'h0, mem_rdata, offset, func3);
              state     <= RESP;
            end
          end
        end
        RD1: begin
          if (mem_rd_ready) begin
            mem_rd_valid <= 1'b0;
            state        <= WAIT1;
          end
        end
        WAIT1: begin
          if (mem_rdata_valid) begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_data  <= align_extend(mem_rdata, word0, offset, func3);
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state        <= IDLE;
          req_ready    <= 1'b1;
          mem_rd_valid <= 1'b0;
          rsp_valid    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
